alu_resp_checker: RTL and testbench
===================================

# alu_resp_checker

Sequencing response checker for the 16-bit two-operand ALU (ops ADD/SUB/AND/OR, outputs `o` and `cout`). It is the consuming end of the ALU vector interface.

- Each cycle, a stimulus source drives `{op, i0, i1}` and the ALU produces `{cout, o}`.
- The block samples the full tuple, recomputes the golden result internally, compares it against the ALU output, and accumulates a verdict over a run of `NVEC` samples.
- It sits beside the ALU in self-checking benches and on-board BIST wrappers. No software golden file is needed.

## Interface

Parameters:
- `WIDTH`, default 16: operand/result width.
- `NVEC`, default 16: samples per run.
- `CW`, default `$clog2(NVEC+1)`: counter width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock, sampled on the rising edge.
- `start`  in  1  begin a run; honoured in IDLE and DONE only.
- `vld`  in  1  sample strobe; `op/i0/i1/o/cout` are valid this cycle.
- `op`  in  2  ALU opcode applied.
- `i0`, `i1`  in  WIDTH  ALU operands applied.
- `o`  in  WIDTH  ALU result observed.
- `cout`  in  1  ALU carry observed.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done && err_cnt==0`.
- `smp_cnt`  out  CW  samples accepted this run.
- `err_cnt`  out  CW  mismatches this run.
- `ff_idx`  out  CW  0-based index of the first failing sample.
- `ff_got`  out  WIDTH+1  `{cout,o}` of the first failure.
- `ff_exp`  out  WIDTH+1  expected `{cout,o}` of the first failure.

## Operation

Golden model, with results truncated to WIDTH:
- 00 ADD: `{cout,o} = i0 + i1` (WIDTH+1-bit sum).
- 01 SUB: `{cout,o} = i0 + ~i1 + 1`; `cout=1` means no borrow.
- 10 AND: `o = i0 & i1`, `cout=0`.
- 11 OR: `o = i0 | i1`, `cout=0`.

A mismatch is any bit differing in the WIDTH+1-bit `{cout,o}`.

FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: `start` -> RUN; clear all counters and first-fail registers.
- RUN: `vld` accepts a sample and increments `smp_cnt`. When the accepted sample is number `NVEC`, go to DRAIN. `start` is ignored.
- DRAIN: unconditional -> DONE after one cycle.
- DONE: hold all results. `start` -> RUN with the same clears as IDLE.
- `vld` is ignored outside RUN. No sample is accepted on the `start` edge itself.

Pipeline:
- Stage 1 registers the mismatch flag, index, got and expected values of the accepted sample.
- Stage 2 updates `err_cnt`. On the first mismatch only, it loads the `ff_*` registers.
- Later mismatches increment `err_cnt` only.
- `err_cnt` saturates at `2^CW-1`; this is unreachable at `NVEC` but required.

Reset (any cycle, including mid-run): state -> IDLE; every output and internal register -> 0 (`busy=done=pass=0`, all counts and `ff_*` zero). Pipeline contents are discarded.

## Timing

- Sample accepted at edge k (`vld=1`, RUN): `smp_cnt` updates at edge k; its contribution to `err_cnt`/`ff_*` is visible after edge k+1.
- Last sample at edge k: state -> DRAIN at k, DONE at k+1; `done`/`pass`/`err_cnt` are final and consistent from edge k+1.
- `start` at edge k in DONE: the clears are visible after k, `busy=1`, and the first sample can be accepted at k+1.
- Back-to-back `vld` every cycle is supported with no stalls; gaps of any length are allowed.

## Structure

- `alu_pkg` holds:
  - opcode localparams `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`;
  - the FSM state encoding;
  - function `alu_golden(op,i0,i1)` returning WIDTH+1 bits.
- One sub-module: `alu_ref_model`, combinational, wrapping `alu_golden` and reusable by other checkers.
- FSM and counters live in `alu_resp_checker`.

## Test plan

- **Clean run.** Reset, `start`, then 16 `vld` cycles with correct responses. Vectors include:
  - ADD aa55+55aa -> `{0,ffff}`
  - ADD ffff+0001 -> `{1,0000}`
  - SUB 0001-7fff -> `{0,8002}`
  - SUB aa55-55aa -> `{1,54ab}`
  - AND ffff&0001 -> `{0,0001}`
  - OR 0001|7fff -> `{0,7fff}`

  Required: `done=1`, `pass=1`, `err_cnt=0`, `smp_cnt=16` one cycle after the last sample.
- **Single fault.** Sample 6 is SUB ffff-0001 driven with `o=fffd`, `cout=1`. Required: `err_cnt=1`, `ff_idx=6`, `ff_got=1_fffd`, `ff_exp=1_fffe`, `pass=0`.
- **Two faults.** Fault at sample 3 (carry flipped on ADD ffff+0001, got `{0,0000}`) and at sample 10. Required: `err_cnt=2`, `ff_idx=3`, `ff_got=0_0000`, `ff_exp=1_0000`.
- **Gapped strobe.** `vld` asserted every third cycle, 16 samples. Required: the same verdict as the clean run; `done` one cycle after the 16th strobe.
- **Reset mid-run.** Assert `reset` after 5 samples, one of them faulty. Required: all outputs 0 next cycle, state IDLE; a following clean run gives `pass=1`.
- **start handling.** `start` pulsed during RUN is ignored (`smp_cnt` continues). `start` in DONE clears the counters (`err_cnt=0`, `done=0`, `busy=1`) and begins a new run.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU response-checker family.
//   - ALU opcode encodings (ALU_ADD / ALU_SUB / ALU_AND / ALU_OR)
//   - checker FSM state encoding (chk_state_e)
//   - alu_golden(): reference {cout,o} for any operand width up to ALU_MAX_W
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // Widest operand the golden function can model.
  localparam int ALU_MAX_W = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } chk_state_e;

  // Operands arrive zero-extended to ALU_MAX_W. 'width' is the real operand
  // width: the result keeps that many bits and the carry lands at bit 'width'.
  // Callers take bits [width:0] of the return value.
  function automatic logic [ALU_MAX_W:0] alu_golden(
    input logic [1:0]           op,
    input logic [ALU_MAX_W-1:0] i0,
    input logic [ALU_MAX_W-1:0] i1,
    input int unsigned          width
  );
    logic [ALU_MAX_W:0] one_s;
    logic [ALU_MAX_W:0] carry_bit_s;
    logic [ALU_MAX_W:0] mask_s;
    logic [ALU_MAX_W:0] sum_s;
    logic [ALU_MAX_W:0] zero_s;
    logic [ALU_MAX_W:0] res_s;
    zero_s      = {(ALU_MAX_W+1){1'b0}};
    one_s       = {{ALU_MAX_W{1'b0}}, 1'b1};
    carry_bit_s = one_s << width;
    mask_s      = carry_bit_s - one_s;
    case (op)
      ALU_ADD: sum_s = {1'b0, i0} + {1'b0, i1};
      // Two's-complement subtract: the inverted operand must be confined to
      // 'width' bits so the carry out of bit width-1 means "no borrow".
      ALU_SUB: sum_s = {1'b0, i0} + ({1'b0, ~i1} & mask_s) + one_s;
      ALU_AND: sum_s = {1'b0, i0 & i1};
      ALU_OR:  sum_s = {1'b0, i0 | i1};
      default: sum_s = zero_s;
    endcase
    // Keep the result bits, then place the carry directly above them.
    res_s = (sum_s & mask_s) |
            (((sum_s & carry_bit_s) != zero_s) ? carry_bit_s : zero_s);
    return res_s;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// -----------------------------------------------------------------------------
// alu_ref_model
// Combinational golden ALU. Wraps alu_pkg::alu_golden so any checker can drop
// in a WIDTH-bit reference without touching the package function directly.
// Ports:
//   op      in  2        ALU opcode
//   i0, i1  in  WIDTH    operands
//   exp_res out WIDTH+1  expected {cout,o}
// -----------------------------------------------------------------------------
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH:0]   exp_res
);

  logic [ALU_MAX_W:0] full_s;

  // Golden result evaluated at the package's maximum width.
  always_comb begin
    full_s = alu_golden(op, ALU_MAX_W'(i0), ALU_MAX_W'(i1), WIDTH);
  end

  assign exp_res = full_s[WIDTH:0];

  // Bits above the carry are always zero; fold them so nothing dangles.
  generate
    if (WIDTH < ALU_MAX_W) begin : g_hi
      logic unused_hi_s;
      assign unused_hi_s = |full_s[ALU_MAX_W:WIDTH+1];
    end
  endgenerate

endmodule

// File: rtl/alu_resp_checker.sv
// -----------------------------------------------------------------------------
// alu_resp_checker
// Consuming end of the ALU vector interface. Samples {op,i0,i1,cout,o} on each
// vld strobe during a run, recomputes the golden result, and accumulates a
// verdict over NVEC samples, capturing the first failing sample.
// Ports:
//   clk      in  1        clock, rising edge
//   reset    in  1        synchronous active-high reset
//   start    in  1        begin a run (honoured in IDLE and DONE)
//   vld      in  1        sample strobe
//   op       in  2        applied opcode
//   i0, i1   in  WIDTH    applied operands
//   o        in  WIDTH    observed result
//   cout     in  1        observed carry
//   busy     out 1        run in progress (RUN or DRAIN)
//   done     out 1        run complete (DONE)
//   pass     out 1        done with zero mismatches
//   smp_cnt  out CW       samples accepted this run
//   err_cnt  out CW       mismatches this run (saturating)
//   ff_idx   out CW       index of first failing sample
//   ff_got   out WIDTH+1  observed {cout,o} of first failure
//   ff_exp   out WIDTH+1  expected {cout,o} of first failure
// -----------------------------------------------------------------------------
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NVEC  = 16,
  parameter int CW    = $clog2(NVEC+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vld,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] o,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    smp_cnt,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    ff_idx,
  output logic [WIDTH:0]   ff_got,
  output logic [WIDTH:0]   ff_exp
);

  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]  LAST_IDX = CW'(NVEC-1);
  localparam logic [WIDTH:0] RES_ZERO = {(WIDTH+1){1'b0}};

  chk_state_e state_r;
  chk_state_e state_nxt_s;

  logic accept_s;   // sample taken this cycle
  logic clear_s;    // run (re)start: wipe counters, first-fail and pipeline

  logic [WIDTH:0] exp_s;
  logic [WIDTH:0] got_s;
  logic           mis_s;

  // Stage 1: the accepted sample, already compared.
  logic           s1_vld_r;
  logic           s1_mis_r;
  logic [CW-1:0]  s1_idx_r;
  logic [WIDTH:0] s1_got_r;
  logic [WIDTH:0] s1_exp_r;

  // Stage 2: run results.
  logic [CW-1:0]  smp_cnt_r;
  logic [CW-1:0]  err_cnt_r;
  logic [CW-1:0]  ff_idx_r;
  logic [WIDTH:0] ff_got_r;
  logic [WIDTH:0] ff_exp_r;
  logic [CW-1:0]  err_cnt_nxt_s;
  logic           ff_load_s;

  logic busy_r;
  logic done_r;
  logic pass_r;

  alu_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .op      (op),
    .i0      (i0),
    .i1      (i1),
    .exp_res (exp_s)
  );

  assign got_s = {cout, o};
  assign mis_s = (got_s != exp_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the accept/clear strobes derived from it.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here.
        if (vld) begin
          accept_s = 1'b1;
          if (smp_cnt_r == LAST_IDX) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Stage-2 update: count a mismatch, and load first-fail only on the first.
  always_comb begin
    err_cnt_nxt_s = err_cnt_r;
    ff_load_s     = 1'b0;
    if (s1_vld_r && s1_mis_r) begin
      ff_load_s = (err_cnt_r == CNT_ZERO);
      if (err_cnt_r != CNT_MAX) begin
        err_cnt_nxt_s = err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_nxt_s = CNT_MAX;
      end
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // Stage 1: capture the compared sample and its 0-based index.
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      s1_vld_r <= 1'b0;
      s1_mis_r <= 1'b0;
      s1_idx_r <= CNT_ZERO;
      s1_got_r <= RES_ZERO;
      s1_exp_r <= RES_ZERO;
    end else if (accept_s) begin
      s1_vld_r <= 1'b1;
      s1_mis_r <= mis_s;
      s1_idx_r <= smp_cnt_r;
      s1_got_r <= got_s;
      s1_exp_r <= exp_s;
    end else begin
      s1_vld_r <= 1'b0;
      s1_mis_r <= s1_mis_r;
      s1_idx_r <= s1_idx_r;
      s1_got_r <= s1_got_r;
      s1_exp_r <= s1_exp_r;
    end
  end

  // Sample counter advances on the accepting edge itself.
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      smp_cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      smp_cnt_r <= smp_cnt_r + CNT_ONE;
    end else begin
      smp_cnt_r <= smp_cnt_r;
    end
  end

  // Stage 2: error counter and first-fail capture.
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      err_cnt_r <= CNT_ZERO;
      ff_idx_r  <= CNT_ZERO;
      ff_got_r  <= RES_ZERO;
      ff_exp_r  <= RES_ZERO;
    end else if (ff_load_s) begin
      err_cnt_r <= err_cnt_nxt_s;
      ff_idx_r  <= s1_idx_r;
      ff_got_r  <= s1_got_r;
      ff_exp_r  <= s1_exp_r;
    end else begin
      err_cnt_r <= err_cnt_nxt_s;
      ff_idx_r  <= ff_idx_r;
      ff_got_r  <= ff_got_r;
      ff_exp_r  <= ff_exp_r;
    end
  end

  // Status flags, registered from the next state so they align with it.
  // pass looks at the next error count because the final stage-2 update
  // lands on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done_r <= (state_nxt_s == ST_DONE);
      pass_r <= (state_nxt_s == ST_DONE) && !clear_s &&
                (err_cnt_nxt_s == CNT_ZERO);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign pass    = pass_r;
  assign smp_cnt = smp_cnt_r;
  assign err_cnt = err_cnt_r;
  assign ff_idx  = ff_idx_r;
  assign ff_got  = ff_got_r;
  assign ff_exp  = ff_exp_r;

endmodule

// File: tb/tb_alu_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_resp_checker
// Directed bench for alu_resp_checker. A run-level behavioural model tracks
// what every output must read after each clock edge; one compare process
// checks the DUT against it on every falling edge, and literal expectations
// pin both the model's golden arithmetic and the key results of each run.
// -----------------------------------------------------------------------------
module tb_alu_resp_checker;

  localparam int NV  = 16;
  localparam int CWL = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        vld = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] i0 = 16'h0000;
  logic [15:0] i1 = 16'h0000;
  logic [15:0] o = 16'h0000;
  logic        cout = 1'b0;
  logic        busy, done, pass;
  logic [CWL-1:0] smp_cnt, err_cnt, ff_idx;
  logic [16:0] ff_got, ff_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_resp_checker #(.WIDTH(16), .NVEC(NV)) dut (
    .clk(clk), .reset(reset), .start(start), .vld(vld), .op(op),
    .i0(i0), .i1(i1), .o(o), .cout(cout), .busy(busy), .done(done),
    .pass(pass), .smp_cnt(smp_cnt), .err_cnt(err_cnt), .ff_idx(ff_idx),
    .ff_got(ff_got), .ff_exp(ff_exp)
  );

  // Vector table: index i is sample i of every run.
  logic [1:0]  v_op [NV] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0,
                             2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] v_a  [NV] = '{16'haa55, 16'h0001, 16'haa55, 16'hffff,
                             16'hffff, 16'h0001, 16'hffff, 16'h1234,
                             16'h0000, 16'haaaa, 16'haaaa, 16'h8000,
                             16'h8000, 16'hf0f0, 16'h0f0f, 16'h7fff};
  logic [15:0] v_b  [NV] = '{16'h55aa, 16'h7fff, 16'h55aa, 16'h0001,
                             16'h0001, 16'h7fff, 16'h0001, 16'h4321,
                             16'h0001, 16'h5555, 16'h5555, 16'h8000,
                             16'h8000, 16'hff00, 16'h00f0, 16'h0001};

  // Golden ALU in plain arithmetic: SUB carry is "a >= b" (no borrow).
  function automatic logic [16:0] golden(input logic [1:0] f, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] d;
    case (f)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    begin d = a - b; return {(a >= b), d}; end
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- run-level model ----------------
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;
  bit          m_valid = 1'b0;
  int          m_phase = PH_IDLE;
  int          m_smp = 0, m_err = 0, m_ffidx = 0;
  logic [16:0] m_ffgot = 17'h0, m_ffexp = 17'h0;
  bit          p_has = 1'b0, p_bad = 1'b0;
  int          p_idx = 0;
  logic [16:0] p_got = 17'h0, p_exp = 17'h0;

  // Model update on each rising edge, from the inputs held across it.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_valid = 1'b1; m_phase = PH_IDLE; m_smp = 0; m_err = 0; m_ffidx = 0;
        m_ffgot = 17'h0; m_ffexp = 17'h0; p_has = 1'b0;
      end else begin
        // A sample accepted last edge is scored one edge later.
        if (p_has) begin
          if (p_bad) begin
            if (m_err == 0) begin
              m_ffidx = p_idx; m_ffgot = p_got; m_ffexp = p_exp;
            end
            if (m_err < 31) m_err++;
          end
          p_has = 1'b0;
        end
        case (m_phase)
          PH_IDLE, PH_DONE: begin
            if (start) begin
              m_phase = PH_RUN; m_smp = 0; m_err = 0; m_ffidx = 0;
              m_ffgot = 17'h0; m_ffexp = 17'h0;
            end
          end
          PH_RUN: begin
            if (vld) begin
              p_has = 1'b1; p_idx = m_smp; p_got = {cout, o};
              p_exp = golden(op, i0, i1); p_bad = (p_got != p_exp);
              m_smp++;
              if (m_smp == NV) m_phase = PH_DRAIN;
            end
          end
          default: m_phase = PH_DONE;
        endcase
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy", 32'(busy), 32'(m_phase == PH_RUN || m_phase == PH_DRAIN));
        chk("done", 32'(done), 32'(m_phase == PH_DONE));
        chk("pass", 32'(pass), 32'(m_phase == PH_DONE && m_err == 0));
        chk("smp_cnt", 32'(smp_cnt), 32'(m_smp));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("ff_idx", 32'(ff_idx), 32'(m_ffidx));
        chk("ff_got", 32'(ff_got), 32'(m_ffgot));
        chk("ff_exp", 32'(ff_exp), 32'(m_ffexp));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start();
    @(negedge clk);
    vld = 1'b0; start = 1'b1;
  endtask

  // Drive n samples; samples fa/fb get their response XORed with ma/mb.
  // gap idle cycles follow each sample; start is pulsed with sample st_at.
  task automatic run_vectors(input int n, input int fa, input logic [16:0] ma,
                             input int fb, input logic [16:0] mb,
                             input int gap, input int st_at);
    logic [16:0] r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op = v_op[i]; i0 = v_a[i]; i1 = v_b[i];
      r = golden(v_op[i], v_a[i], v_b[i]);
      if (i == fa) r = r ^ ma;
      if (i == fb) r = r ^ mb;
      {cout, o} = r;
      vld = 1'b1;
      start = (i == st_at);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        vld = 1'b0; start = 1'b0;
      end
    end
    @(negedge clk);
    vld = 1'b0; start = 1'b0;
  endtask

  // Literal checks one cycle after the last sample.
  task automatic final_chk(input string nm, input int e_err, input bit e_pass);
    @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_pass"}, 32'(pass), 32'(e_pass));
    chk({nm, "_err"}, 32'(err_cnt), 32'(e_err));
    chk({nm, "_smp"}, 32'(smp_cnt), 32'd16);
  endtask

  initial begin
    // Reset state.
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_smp", 32'(smp_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);

    // Pin the model's arithmetic with hand-computed values.
    chk("gold_add_aa55", 32'(golden(2'd0, 16'haa55, 16'h55aa)), 32'h0ffff);
    chk("gold_add_ffff", 32'(golden(2'd0, 16'hffff, 16'h0001)), 32'h10000);
    chk("gold_sub_0001", 32'(golden(2'd1, 16'h0001, 16'h7fff)), 32'h08002);
    chk("gold_sub_aa55", 32'(golden(2'd1, 16'haa55, 16'h55aa)), 32'h154ab);
    chk("gold_and", 32'(golden(2'd2, 16'hffff, 16'h0001)), 32'h00001);
    chk("gold_or", 32'(golden(2'd3, 16'h0001, 16'h7fff)), 32'h07fff);
    chk("gold_sub_ffff", 32'(golden(2'd1, 16'hffff, 16'h0001)), 32'h1fffe);

    // Clean run, back-to-back strobes.
    do_start();
    run_vectors(NV, -1, 17'h0, -1, 17'h0, 0, -1);
    final_chk("clean", 0, 1'b1);

    // Single fault: sample 6 answered with {1,fffd}.
    do_start();
    run_vectors(NV, 6, 17'h00003, -1, 17'h0, 0, -1);
    final_chk("single", 1, 1'b0);
    chk("single_ff_idx", 32'(ff_idx), 32'd6);
    chk("single_ff_got", 32'(ff_got), 32'h1fffd);
    chk("single_ff_exp", 32'(ff_exp), 32'h1fffe);

    // start in DONE clears the previous verdict.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err", 32'(err_cnt), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_smp", 32'(smp_cnt), 32'd0);

    // Two faults: carry flipped on sample 3, bit 8 flipped on sample 10.
    run_vectors(NV, 3, 17'h10000, 10, 17'h00100, 0, -1);
    final_chk("two", 2, 1'b0);
    chk("two_ff_idx", 32'(ff_idx), 32'd3);
    chk("two_ff_got", 32'(ff_got), 32'h00000);
    chk("two_ff_exp", 32'(ff_exp), 32'h10000);

    // Gapped strobe (every third cycle) with a stray start mid-run.
    do_start();
    run_vectors(NV, -1, 17'h0, -1, 17'h0, 2, 5);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_pass", 32'(pass), 32'd1);
    chk("gap_smp", 32'(smp_cnt), 32'd16);

    // Reset mid-run after 5 samples, sample 2 faulty.
    do_start();
    run_vectors(5, 2, 17'h00010, -1, 17'h0, 0, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err_cnt), 32'd0);
    chk("midrst_smp", 32'(smp_cnt), 32'd0);
    chk("midrst_ff", 32'(ff_got), 32'd0);

    // Clean run after the reset.
    do_start();
    run_vectors(NV, -1, 17'h0, -1, 17'h0, 0, -1);
    final_chk("post_rst", 0, 1'b1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
